// File: rtl/sc_fsm_func.sv
// -----------------------------------------------------------------------------
// sc_fsm_func
//
// Multi-channel stochastic-computing FSM function unit. Each channel holds a
// saturating up/down state counter stepped by its own input bitstream. A shared
// run-time mode decodes every channel's state into an output bitstream:
// stochastic tanh, absolute value, or exponential.
//
// Parameters
//   S  state counter width (2..10); each channel has 2^S states
//   C  number of independent channels
//   G  EXP-mode gain offset (1 .. 2^(S-1)-1)
//
// Ports
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous active-high; re-centres every channel to 2^(S-1)
//   en     in   1  stream-valid strobe shared by all channels
//   clr    in   1  synchronous re-centre of all channels; beats en
//   mode   in   2  decode select: 0 TANH, 1 ABS, 2 EXP, 3 reserved (y = 0)
//   x      in   C  input bitstreams, bit i drives channel i
//   y      out  C  output bitstreams, combinational from state and mode
//   sat    out  C  saturation flags (only when SC_FSM_FUNC_SAT_FLAG_EN is defined)
//
// Optional feature macro: SC_FSM_FUNC_SAT_FLAG_EN adds the sat port and its
// flag logic; without it the unit is otherwise identical.
// -----------------------------------------------------------------------------
module sc_fsm_func #(
  parameter int S = 6,
  parameter int C = 4,
  parameter int G = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [1:0]   mode,
  input  logic [C-1:0] x,
`ifdef SC_FSM_FUNC_SAT_FLAG_EN
  output logic [C-1:0] y,
  output logic [C-1:0] sat
`else
  output logic [C-1:0] y
`endif
);

  typedef enum logic [1:0] {
    MODE_TANH = 2'd0,
    MODE_ABS  = 2'd1,
    MODE_EXP  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  localparam logic [S-1:0] CENTER  = S'(2 ** (S - 1));
  localparam logic [S-1:0] TOP     = S'((2 ** S) - 1);
  localparam logic [S-1:0] ONE     = S'(1);
  // Highest state that still decodes to 1 in EXP mode.
  localparam logic [S-1:0] EXP_MAX = S'((2 ** S) - 1 - G);

  logic [S-1:0] st     [C];
  logic [S-1:0] st_nxt [C];
  mode_t        mode_e;

  // Counters clamp at both ends instead of wrapping.
  function automatic logic [S-1:0] sat_inc(input logic [S-1:0] v);
    return (v == TOP) ? v : v + ONE;
  endfunction

  function automatic logic [S-1:0] sat_dec(input logic [S-1:0] v);
    return (v == '0) ? v : v - ONE;
  endfunction

  // Next-state: clr beats en; en low holds.
  always_comb begin
    for (int i = 0; i < C; i++) begin
      st_nxt[i] = st[i];
      if (clr) begin
        st_nxt[i] = CENTER;
      end else if (en) begin
        st_nxt[i] = x[i] ? sat_inc(st[i]) : sat_dec(st[i]);
      end
    end
  end

  // State register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < C; i++) begin
        st[i] <= CENTER;
      end
    end else begin
      for (int i = 0; i < C; i++) begin
        st[i] <= st_nxt[i];
      end
    end
  end

  // Moore decode: y depends only on registered state and mode.
  assign mode_e = mode_t'(mode);

  always_comb begin
    y = '0;
    for (int i = 0; i < C; i++) begin
      case (mode_e)
        MODE_TANH: y[i] = st[i][S-1];
        // Lower half counts parity inverted so the output is symmetric about
        // the centre state.
        MODE_ABS:  y[i] = st[i][S-1] ? st[i][0] : ~st[i][0];
        MODE_EXP:  y[i] = (st[i] <= EXP_MAX);
        default:   y[i] = 1'b0;
      endcase
    end
  end

`ifdef SC_FSM_FUNC_SAT_FLAG_EN
  always_comb begin
    sat = '0;
    for (int i = 0; i < C; i++) begin
      sat[i] = (st[i] == '0) || (st[i] == TOP);
    end
  end
`endif

endmodule

// File: doc/sc_fsm_func.md
# sc_fsm_func

Multi-channel, mode-selectable stochastic-computing FSM function unit. Each channel is a saturating up/down state counter driven by one stochastic bitstream. A shared run-time mode decodes each channel's state into an output bitstream: stochastic tanh, absolute value, or exponential. It sits after SC encoders (SNGs) and before the SC accumulators/decoders. It replaces the fixed-function single-channel FSM blocks with one parametrised unit.

## Interface
- `S`, 6: state counter width; each channel has 2^S states (0 .. 2^S-1); legal range 2..10.
- `C`, 4: number of independent channels.
- `G`, 2: EXP-mode gain offset; legal range 1 .. 2^(S-1)-1.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; forces every channel state to 2^(S-1).
- `en`  in  1  stream-valid strobe shared by all channels; the counter moves only when high.
- `clr`  in  1  synchronous re-centre of all channels to 2^(S-1); has priority over `en`.
- `mode`  in  2  output decode: 0 TANH, 1 ABS, 2 EXP, 3 reserved.
- `x`  in  C  input bitstreams, bit i drives channel i.
- `y`  out  C  output bitstreams, bit i from channel i.
- `sat`  out  C  saturation flags; present only with `SC_FSM_FUNC_SAT_FLAG_EN`.

## Operation
- Per channel i, the state register `st[i]` is S bits wide and unsigned. The reset value is 2^(S-1).
- Next-state priority on each rising edge:
  - `clr`=1: `st[i]` <= 2^(S-1).
  - else `en`=1 and `x[i]`=1: `st[i]` <= `st[i]`+1, saturating at 2^S-1.
  - else `en`=1 and `x[i]`=0: `st[i]` <= `st[i]`-1, saturating at 0.
  - else: hold.
- Saturation boundaries:
  - At 2^S-1 with `x`=1, stay at 2^S-1; the counter never wraps to 0.
  - At 0 with `x`=0, stay at 0; the counter never wraps to 2^S-1.
- Output decode is a Moore function of (`st[i]`, `mode`); `x` has no direct path to `y`.
  - TANH: `y[i]` = `st[i]`[S-1], i.e. 1 when `st[i]` >= 2^(S-1).
  - ABS: if `st[i]`[S-1]=0, `y[i]` = ~`st[i]`[0]; else `y[i]` = `st[i]`[0].
  - EXP: `y[i]` = 1 when `st[i]` <= 2^S-1-G, else 0.
  - Reserved (3): `y` = all zeros.
- `mode` changes only the decode and never disturbs `st`. A mode switch mid-stream takes effect combinationally, with no flush.
- Channels are fully independent. They share only `en`, `clr`, `mode` and reset.

## Timing
- Latency: the `x` bit sampled at edge k affects `y` immediately after edge k (one-cycle register latency, zero decode latency).
- `y` and `sat` are combinational from registered state and `mode`; no additional output register.
- Output values after reset (state 2^(S-1), with S>=2):
  - TANH: `y` = all ones.
  - ABS: `y` = all zeros.
  - EXP: `y` = all ones (because G <= 2^(S-1)-1).
  - Reserved: `y` = all zeros.
  - `sat` = all zeros.
- Reset asserted mid-stream: all states go to 2^(S-1) asynchronously and `y` follows the same cycle. Release is synchronous to `clk`.
- `clr` and `en` high in the same cycle: `clr` wins and the `x` bit is discarded.
- `en` low: `x` is ignored and `y` is stable.

## Configuration
- Macro: `SC_FSM_FUNC_SAT_FLAG_EN`.
- Defined: port `sat[C-1:0]` exists. `sat[i]` = 1 when `st[i]` is 0 or 2^S-1; combinational from state; 0 after reset and after `clr`.
- Undefined: no `sat` port and no flag logic. All other behaviour is identical.

## Test plan
All scenarios use S=4, C=2, G=2, so the centre is 8 and the top state is 15.
- Reset with mode=0 -> `y`=2'b11; switch to mode=1 -> `y`=2'b00; mode=3 -> `y`=2'b00; `sat`=2'b00.
- mode=0, en=1, x[0]=1 for 10 cycles -> `st[0]` steps 9..15 and then holds 15. `sat[0]` rises after the 7th edge. `y[0]`=1 throughout.
- mode=1, en=1, x[1]=0 for 10 cycles -> `st[1]` steps 7..0 and then holds 0. `y[1]` toggles 0,1,0,...; it is 1 at state 0. `sat[1]`=1 from the 8th edge.
- en=0 with random x for 20 cycles after any state -> states, `y` and `sat` unchanged.
- en=1 and x=2'b11 to reach state 12, then clr=1 with en=1 and x=2'b11 for one cycle -> both states = 8 on the next edge. Also assert reset mid-stream -> states = 8 asynchronously.
- mode=2, en=1, x[0]=1 from state 8 -> `y[0]`=1 at states 8..13 and 0 at states 14 and 15. Then drive x[0]=0 -> `y[0]` returns to 1 once the state reaches 13.
